// File: rtl/gfx_ddr_write_arbiter_pkg.sv
// Shared definitions for the graphics DDR2 write-port arbiter: state encoding,
// MIG command constant and default bus widths.
package gfx_ddr_write_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBeat1 = 2'd1,
    StBeat2 = 2'd2
  } arb_state_e;

  localparam logic [2:0] WRITE_CMD = 3'b000;

  localparam int unsigned DEF_ADDR_W = 31;
  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_MASK_W = 16;
  localparam int unsigned DEF_CNT_W  = 32;

endpackage

// File: rtl/gfx_ddr_write_arbiter_if.sv
// Bundle of the two graphics requester write ports and the MIG write-FIFO port.
// slave is the arbiter's view; master is the engines/MIG side.
interface gfx_ddr_write_arbiter_if
  import gfx_ddr_write_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned MASK_W = DEF_MASK_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
);
  logic              req0;
  logic [ADDR_W-1:0] af_addr0;
  logic              af_wr_en0;
  logic [DATA_W-1:0] wdf_din0;
  logic [MASK_W-1:0] wdf_mask0;
  logic              wdf_wr_en0;
  logic              af_full0;
  logic              wdf_full0;

  logic              req1;
  logic [ADDR_W-1:0] af_addr1;
  logic              af_wr_en1;
  logic [DATA_W-1:0] wdf_din1;
  logic [MASK_W-1:0] wdf_mask1;
  logic              wdf_wr_en1;
  logic              af_full1;
  logic              wdf_full1;

  logic              af_full;
  logic              wdf_full;
  logic [2:0]        af_cmd_din;
  logic [ADDR_W-1:0] af_addr_din;
  logic              af_wr_en;
  logic [DATA_W-1:0] wdf_din;
  logic [MASK_W-1:0] wdf_mask_din;
  logic              wdf_wr_en;

  logic [CNT_W-1:0]  bursts0;
  logic [CNT_W-1:0]  bursts1;

  modport slave (
    input  req0, af_addr0, af_wr_en0, wdf_din0, wdf_mask0, wdf_wr_en0,
    output af_full0, wdf_full0,
    input  req1, af_addr1, af_wr_en1, wdf_din1, wdf_mask1, wdf_wr_en1,
    output af_full1, wdf_full1,
    input  af_full, wdf_full,
    output af_cmd_din, af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en,
    output bursts0, bursts1
  );

  modport master (
    output req0, af_addr0, af_wr_en0, wdf_din0, wdf_mask0, wdf_wr_en0,
    input  af_full0, wdf_full0,
    output req1, af_addr1, af_wr_en1, wdf_din1, wdf_mask1, wdf_wr_en1,
    input  af_full1, wdf_full1,
    output af_full, wdf_full,
    input  af_cmd_din, af_addr_din, af_wr_en, wdf_din, wdf_mask_din, wdf_wr_en,
    input  bursts0, bursts1
  );

endinterface

// File: rtl/gfx_ddr_write_arbiter_rr_arb2.sv
// Two-requester round-robin picker: a lone request wins, a tie goes to !last.
// grant is only meaningful when at least one request is high.
module gfx_ddr_write_arbiter_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);

  always_comb begin
    if (req0 && req1) begin
      grant = ~last;
    end else begin
      grant = req1;
    end
  end

endmodule

// File: rtl/gfx_ddr_write_arbiter.sv
// Shares the MIG write port between the line engine (0) and fill engine (1),
// granting whole two-beat bursts round-robin at burst boundaries.
module gfx_ddr_write_arbiter
  import gfx_ddr_write_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned MASK_W = DEF_MASK_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input logic                    clk,
  input logic                    rst,
  gfx_ddr_write_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] bursts0_q, bursts0_d;
  logic [CNT_W-1:0] bursts1_q, bursts1_d;

  logic              any_req;
  logic              pri_last;
  logic              grant;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_din;
  logic [MASK_W-1:0] own_mask;
  logic              own_af_en;
  logic              own_wdf_en;
  logic              beat1_ok;
  logic              beat2_ok;
  logic              own_af_full;
  logic              own_wdf_full;
  logic              active;

  assign any_req = bus.req0 | bus.req1;

  // At a burst boundary the finishing owner becomes the new 'last' in the same cycle.
  assign pri_last = (state_q == StBeat2) ? owner_q : last_q;

  gfx_ddr_write_arbiter_rr_arb2 u_rr_arb2 (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .last  (pri_last),
    .grant (grant)
  );

  assign own_addr   = owner_q ? bus.af_addr1   : bus.af_addr0;
  assign own_din    = owner_q ? bus.wdf_din1   : bus.wdf_din0;
  assign own_mask   = owner_q ? bus.wdf_mask1  : bus.wdf_mask0;
  assign own_af_en  = owner_q ? bus.af_wr_en1  : bus.af_wr_en0;
  assign own_wdf_en = owner_q ? bus.wdf_wr_en1 : bus.wdf_wr_en0;

  assign beat1_ok = (state_q == StBeat1) && own_af_en && own_wdf_en &&
                    !bus.af_full && !bus.wdf_full;
  assign beat2_ok = (state_q == StBeat2) && own_wdf_en && !bus.wdf_full;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    bursts0_d = bursts0_q;
    bursts1_d = bursts1_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StBeat1;
          owner_d = grant;
        end
      end
      StBeat1: begin
        if (beat1_ok) begin
          state_d = StBeat2;
        end
      end
      StBeat2: begin
        if (beat2_ok) begin
          last_d = owner_q;
          if (owner_q) begin
            bursts1_d = bursts1_q + CNT_W'(1);
          end else begin
            bursts0_d = bursts0_q + CNT_W'(1);
          end
          if (any_req) begin
            state_d = StBeat1;
            owner_d = grant;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Full views depend only on state, owner and MIG fulls, never on strobes.
  always_comb begin
    own_af_full  = 1'b1;
    own_wdf_full = 1'b1;
    case (state_q)
      StBeat1: begin
        own_af_full  = bus.af_full | bus.wdf_full;
        own_wdf_full = bus.af_full | bus.wdf_full;
      end
      StBeat2: own_wdf_full = bus.wdf_full;
      default: ;
    endcase
  end

  assign bus.af_full0  = owner_q | own_af_full;
  assign bus.wdf_full0 = owner_q | own_wdf_full;
  assign bus.af_full1  = ~owner_q | own_af_full;
  assign bus.wdf_full1 = ~owner_q | own_wdf_full;

  assign active           = (state_q != StIdle);
  assign bus.af_cmd_din   = WRITE_CMD;
  assign bus.af_addr_din  = active ? own_addr : '0;
  assign bus.wdf_din      = active ? own_din  : '0;
  assign bus.wdf_mask_din = active ? own_mask : '0;
  assign bus.af_wr_en     = beat1_ok;
  assign bus.wdf_wr_en    = beat1_ok | beat2_ok;
  assign bus.bursts0      = bursts0_q;
  assign bus.bursts1      = bursts1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      bursts0_q <= '0;
      bursts1_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      bursts0_q <= bursts0_d;
      bursts1_q <= bursts1_d;
    end
  end

endmodule

// File: tb/tb_gfx_ddr_write_arbiter.sv
// Self-checking bench for gfx_ddr_write_arbiter: directed scenarios plus random
// two-engine traffic checked against a burst-order model.
module tb_gfx_ddr_write_arbiter;
  import gfx_ddr_write_arbiter_pkg::*;

  localparam int unsigned AW = DEF_ADDR_W;
  localparam int unsigned DW = DEF_DATA_W;
  localparam int unsigned MW = DEF_MASK_W;
  localparam int unsigned CW = DEF_CNT_W;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] d1;
    logic [MW-1:0] m1;
    logic [DW-1:0] d2;
    logic [MW-1:0] m2;
  } burst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gfx_ddr_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .CNT_W(CW)) bus ();

  gfx_ddr_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     n_checks = 0;
  int     n_pass = 0;
  burst_t gen0[$], gen1[$], obs[$], exp_q[$];
  int     viol, first_cyc, last_cyc;
  bit     traffic_timeout;
  logic   m_last;

  task automatic drive0(input logic rq, input logic af, input logic wd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
    bus.req0 = rq; bus.af_wr_en0 = af; bus.wdf_wr_en0 = wd;
    bus.af_addr0 = a; bus.wdf_din0 = d; bus.wdf_mask0 = m;
  endtask

  task automatic drive1(input logic rq, input logic af, input logic wd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
    bus.req1 = rq; bus.af_wr_en1 = af; bus.wdf_wr_en1 = wd;
    bus.af_addr1 = a; bus.wdf_din1 = d; bus.wdf_mask1 = m;
  endtask

  task automatic idle_inputs();
    drive0(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive1(1'b0, 1'b0, 1'b0, '0, '0, '0);
    bus.af_full = 1'b0;
    bus.wdf_full = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic make_bursts(input int n0, input int n1);
    burst_t b;
    gen0.delete();
    gen1.delete();
    for (int k = 0; k < n0 + n1; k++) begin
      b.addr = {(k >= n0), 14'(k), 16'($urandom)};
      b.d1 = {$urandom, $urandom, $urandom, $urandom};
      b.d2 = {$urandom, $urandom, $urandom, $urandom};
      b.m1 = 16'($urandom);
      b.m2 = 16'($urandom);
      if (k < n0) gen0.push_back(b);
      else gen1.push_back(b);
    end
  endtask

  // Expected MIG burst order: ties go to the requester that did not finish last.
  function automatic void build_expected(input int n0, input int n1);
    int   r0 = n0, r1 = n1, i0 = 0, i1 = 0;
    logic pick;
    exp_q.delete();
    while (r0 + r1 > 0) begin
      pick = (r0 > 0 && r1 > 0) ? ~m_last : (r1 > 0);
      if (pick) begin exp_q.push_back(gen1[i1]); i1++; r1--; end
      else begin exp_q.push_back(gen0[i0]); i0++; r0--; end
      m_last = pick;
    end
  endfunction

  // Two protocol-following engines plus a MIG monitor recording whole bursts.
  task automatic run_traffic(input int n0, input int n1, input int bp_pct, input int idle_pct);
    int     s0 = 0, s1 = 0, d0 = 0, d1 = 0, ph0 = 0, ph1 = 0, cyc = 0;
    bit     en0, en1, have_b1 = 0;
    burst_t cur = '0;
    obs.delete();
    viol = 0; first_cyc = -1; last_cyc = -1; traffic_timeout = 0;
    while ((d0 < n0 || d1 < n1) && cyc < 2000) begin
      @(negedge clk);
      en0 = ($urandom_range(99) >= idle_pct);
      en1 = ($urandom_range(99) >= idle_pct);
      if (ph0 == 0 && s0 < n0) drive0(1'b1, en0, en0, gen0[s0].addr, gen0[s0].d1, gen0[s0].m1);
      else if (ph0 == 1) drive0(s0 < n0, 1'b0, en0, gen0[s0-1].addr, gen0[s0-1].d2, gen0[s0-1].m2);
      else drive0(1'b0, 1'b0, 1'b0, '0, '0, '0);
      if (ph1 == 0 && s1 < n1) drive1(1'b1, en1, en1, gen1[s1].addr, gen1[s1].d1, gen1[s1].m1);
      else if (ph1 == 1) drive1(s1 < n1, 1'b0, en1, gen1[s1-1].addr, gen1[s1-1].d2, gen1[s1-1].m2);
      else drive1(1'b0, 1'b0, 1'b0, '0, '0, '0);
      bus.af_full = ($urandom_range(99) < bp_pct);
      bus.wdf_full = ($urandom_range(99) < bp_pct);
      #1;
      if (bus.af_wr_en) begin
        if (!bus.wdf_wr_en || bus.af_full || bus.wdf_full || have_b1) viol++;
        cur.addr = bus.af_addr_din; cur.d1 = bus.wdf_din; cur.m1 = bus.wdf_mask_din;
        have_b1 = 1;
        if (first_cyc < 0) first_cyc = cyc;
      end else if (bus.wdf_wr_en) begin
        if (!have_b1 || bus.wdf_full) viol++;
        cur.d2 = bus.wdf_din; cur.m2 = bus.wdf_mask_din;
        obs.push_back(cur);
        have_b1 = 0;
        last_cyc = cyc;
      end
      if (ph0 == 0 && s0 < n0 && en0 && !bus.af_full0 && !bus.wdf_full0) begin s0++; ph0 = 1; end
      else if (ph0 == 1 && en0 && !bus.wdf_full0) begin ph0 = 0; d0++; end
      if (ph1 == 0 && s1 < n1 && en1 && !bus.af_full1 && !bus.wdf_full1) begin s1++; ph1 = 1; end
      else if (ph1 == 1 && en1 && !bus.wdf_full1) begin ph1 = 0; d1++; end
      cyc++;
    end
    if (d0 < n0 || d1 < n1) traffic_timeout = 1;
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({bus.af_full0, bus.wdf_full0, bus.af_full1, bus.wdf_full1} !== 4'hF)
      $display("FAIL reset_fulls: got %b want 1111",
               {bus.af_full0, bus.wdf_full0, bus.af_full1, bus.wdf_full1});
    else n_pass++;
    n_checks++;
    if ({bus.af_wr_en, bus.wdf_wr_en} !== 2'b00)
      $display("FAIL reset_strobes: got %b want 00", {bus.af_wr_en, bus.wdf_wr_en});
    else n_pass++;
    n_checks++;
    if ({bus.bursts0, bus.bursts1} !== '0)
      $display("FAIL reset_counters: got %h/%h want 0/0", bus.bursts0, bus.bursts1);
    else n_pass++;
    n_checks++;
    if ({bus.af_cmd_din, bus.af_addr_din} !== '0)
      $display("FAIL reset_cmd_addr: got %h/%h want 0/0", bus.af_cmd_din, bus.af_addr_din);
    else n_pass++;
  endtask

  task automatic test_single_burst();
    logic [AW-1:0] a = 31'h0041_0000;
    logic [DW-1:0] da = {32{4'hA}};
    logic [DW-1:0] db = {32{4'hB}};
    do_reset();
    @(negedge clk);
    drive0(1'b1, 1'b1, 1'b1, a, da, 16'hFFF0);
    #1;
    n_checks++;
    if (bus.af_wr_en !== 1'b0) $display("FAIL single_latency: af_wr_en got %b want 0", bus.af_wr_en);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.af_wr_en, bus.wdf_wr_en, bus.af_addr_din, bus.wdf_din, bus.wdf_mask_din, bus.af_full1}
        !== {1'b1, 1'b1, a, da, 16'hFFF0, 1'b1})
      $display("FAIL single_beat1: got en=%b%b addr=%h din=%h mask=%h full1=%b",
               bus.af_wr_en, bus.wdf_wr_en, bus.af_addr_din, bus.wdf_din, bus.wdf_mask_din,
               bus.af_full1);
    else n_pass++;
    @(negedge clk);
    drive0(1'b0, 1'b0, 1'b1, a, db, 16'hFFFF);
    #1;
    n_checks++;
    if ({bus.af_wr_en, bus.wdf_wr_en, bus.wdf_din, bus.wdf_mask_din, bus.af_full0, bus.af_full1}
        !== {1'b0, 1'b1, db, 16'hFFFF, 1'b1, 1'b1})
      $display("FAIL single_beat2: got en=%b%b din=%h mask=%h full0/1=%b%b", bus.af_wr_en,
               bus.wdf_wr_en, bus.wdf_din, bus.wdf_mask_din, bus.af_full0, bus.af_full1);
    else n_pass++;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if ({bus.bursts0, bus.bursts1, bus.wdf_wr_en} !== {32'd1, 32'd0, 1'b0})
      $display("FAIL single_count: got %0d/%0d en=%b want 1/0 en=0", bus.bursts0, bus.bursts1,
               bus.wdf_wr_en);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    make_bursts(4, 4);
    build_expected(4, 4);
    run_traffic(4, 4, 0, 0);
    n_checks++;
    if (traffic_timeout || viol != 0 || obs.size() != 8)
      $display("FAIL b2b_protocol: got timeout=%0d viol=%0d bursts=%0d want 0/0/8",
               traffic_timeout, viol, obs.size());
    else n_pass++;
    for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (obs[k] !== exp_q[k])
        $display("FAIL b2b_burst%0d: got addr %h want addr %h", k, obs[k].addr, exp_q[k].addr);
      else n_pass++;
    end
    n_checks++;
    if (last_cyc - first_cyc !== 15)
      $display("FAIL b2b_no_gap: got span %0d want 15", last_cyc - first_cyc);
    else n_pass++;
    n_checks++;
    if ({bus.bursts0, bus.bursts1} !== {32'd4, 32'd4})
      $display("FAIL b2b_counts: got %0d/%0d want 4/4", bus.bursts0, bus.bursts1);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [AW-1:0] a1 = 31'h0012_3400;
    logic [AW-1:0] a0 = 31'h0000_5600;
    logic [DW-1:0] d12 = {4{32'h2222_2222}};
    do_reset();
    @(negedge clk);
    drive1(1'b1, 1'b1, 1'b1, a1, {4{32'h1111_1111}}, 16'h00FF);
    @(negedge clk);
    @(negedge clk);
    drive1(1'b0, 1'b0, 1'b1, a1, d12, 16'h0F0F);
    drive0(1'b1, 1'b1, 1'b1, a0, {4{32'h3333_3333}}, 16'h0000);
    bus.wdf_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({bus.af_wr_en, bus.wdf_wr_en, bus.wdf_full1, bus.af_full0, bus.wdf_full0} !== 5'b00111)
        $display("FAIL stall_cycle%0d: got en=%b%b wdf_full1=%b full0=%b%b", i, bus.af_wr_en,
                 bus.wdf_wr_en, bus.wdf_full1, bus.af_full0, bus.wdf_full0);
      else n_pass++;
      @(negedge clk);
    end
    bus.wdf_full = 1'b0;
    #1;
    n_checks++;
    if ({bus.wdf_wr_en, bus.af_wr_en, bus.wdf_din, bus.wdf_mask_din} !== {2'b10, d12, 16'h0F0F})
      $display("FAIL stall_release: got en=%b%b din=%h mask=%h", bus.wdf_wr_en, bus.af_wr_en,
               bus.wdf_din, bus.wdf_mask_din);
    else n_pass++;
    @(negedge clk);
    drive1(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    n_checks++;
    if ({bus.bursts1, bus.bursts0, bus.af_wr_en, bus.af_addr_din} !== {32'd1, 32'd0, 1'b1, a0})
      $display("FAIL stall_handover: got %0d/%0d af=%b addr=%h", bus.bursts1, bus.bursts0,
               bus.af_wr_en, bus.af_addr_din);
    else n_pass++;
  endtask

  task automatic test_lone_strobe();
    logic [AW-1:0] a = 31'h0000_7700;
    do_reset();
    @(negedge clk);
    drive0(1'b1, 1'b0, 1'b1, a, {4{32'h4444_4444}}, 16'h1234);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.af_wr_en, bus.wdf_wr_en, bus.af_full0} !== 3'b000)
        $display("FAIL lone_wdf%0d: got en=%b%b af_full0=%b want 000", i, bus.af_wr_en,
                 bus.wdf_wr_en, bus.af_full0);
      else n_pass++;
    end
    @(negedge clk);
    drive0(1'b1, 1'b1, 1'b1, a, {4{32'h4444_4444}}, 16'h1234);
    #1;
    n_checks++;
    if ({bus.af_wr_en, bus.wdf_wr_en} !== 2'b11)
      $display("FAIL lone_beat1: got en=%b%b want 11", bus.af_wr_en, bus.wdf_wr_en);
    else n_pass++;
    @(negedge clk);
    drive0(1'b0, 1'b1, 1'b1, a, {4{32'h5555_5555}}, 16'h5678);
    #1;
    n_checks++;
    if ({bus.af_wr_en, bus.wdf_wr_en} !== 2'b01)
      $display("FAIL lone_af_in_beat2: got en=%b%b want 01", bus.af_wr_en, bus.wdf_wr_en);
    else n_pass++;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (bus.bursts0 !== 32'd1) $display("FAIL lone_count: got %0d want 1", bus.bursts0);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [AW-1:0] a0 = 31'h0000_0A00;
    logic [AW-1:0] a1 = 31'h4000_0B00;
    do_reset();
    @(negedge clk);
    drive0(1'b1, 1'b1, 1'b1, a0, {4{32'hA0A0_A0A0}}, 16'h0001);
    drive1(1'b1, 1'b1, 1'b1, a1, {4{32'hB0B0_B0B0}}, 16'h0002);
    @(negedge clk);
    @(negedge clk);
    drive0(1'b1, 1'b0, 1'b1, a0, {4{32'hA1A1_A1A1}}, 16'h0003);
    @(negedge clk);
    drive0(1'b1, 1'b1, 1'b1, a0, {4{32'hA0A0_A0A0}}, 16'h0001);
    @(negedge clk);
    drive1(1'b1, 1'b0, 1'b1, a1, {4{32'hB1B1_B1B1}}, 16'h0004);
    #1;
    n_checks++;
    if ({bus.wdf_wr_en, bus.af_wr_en, bus.bursts0} !== {2'b10, 32'd1})
      $display("FAIL arst_pre: got en=%b%b bursts0=%0d want 10/1", bus.wdf_wr_en, bus.af_wr_en,
               bus.bursts0);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.af_wr_en, bus.wdf_wr_en, bus.af_full0, bus.wdf_full0, bus.af_full1, bus.wdf_full1}
        !== 6'b001111)
      $display("FAIL arst_outputs: got %b want 001111", {bus.af_wr_en, bus.wdf_wr_en,
               bus.af_full0, bus.wdf_full0, bus.af_full1, bus.wdf_full1});
    else n_pass++;
    n_checks++;
    if ({bus.bursts0, bus.bursts1} !== '0)
      $display("FAIL arst_counters: got %0d/%0d want 0/0", bus.bursts0, bus.bursts1);
    else n_pass++;
    #3 rst = 1'b0;
    drive1(1'b1, 1'b1, 1'b1, a1, {4{32'hB0B0_B0B0}}, 16'h0002);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.af_wr_en, bus.af_addr_din, bus.af_full1} !== {1'b1, a0, 1'b1})
      $display("FAIL arst_first_grant: got af=%b addr=%h full1=%b want 1/%h/1", bus.af_wr_en,
               bus.af_addr_din, bus.af_full1, a0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    force dut.bursts0_d = '1;
    @(negedge clk);
    release dut.bursts0_d;
    #1;
    n_checks++;
    if (bus.bursts0 !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %h want ffffffff",
                                                bus.bursts0);
    else n_pass++;
    @(negedge clk);
    drive0(1'b1, 1'b1, 1'b1, 31'h0000_0C00, {4{32'hC0C0_C0C0}}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    drive0(1'b0, 1'b0, 1'b1, 31'h0000_0C00, {4{32'hC1C1_C1C1}}, 16'h0000);
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if ({bus.bursts0, bus.bursts1} !== '0)
      $display("FAIL wrap_count: got %h/%h want 0/0", bus.bursts0, bus.bursts1);
    else n_pass++;
  endtask

  task automatic test_random();
    int n0, n1, e0 = 0, e1 = 0;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      n0 = $urandom_range(5, 1);
      n1 = $urandom_range(5, 0);
      make_bursts(n0, n1);
      build_expected(n0, n1);
      run_traffic(n0, n1, 30, 25);
      e0 += n0;
      e1 += n1;
      n_checks++;
      if (traffic_timeout || viol != 0 || obs.size() != exp_q.size())
        $display("FAIL rand%0d_protocol: got timeout=%0d viol=%0d bursts=%0d want 0/0/%0d", r,
                 traffic_timeout, viol, obs.size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
        n_checks++;
        if (obs[k] !== exp_q[k])
          $display("FAIL rand%0d_burst%0d: got addr %h d1 %h want addr %h d1 %h", r, k,
                   obs[k].addr, obs[k].d1, exp_q[k].addr, exp_q[k].d1);
        else n_pass++;
      end
      n_checks++;
      if ({bus.bursts0, bus.bursts1} !== {32'(e0), 32'(e1)})
        $display("FAIL rand%0d_counts: got %0d/%0d want %0d/%0d", r, bus.bursts0, bus.bursts1,
                 e0, e1);
      else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    m_last = 1'b1;
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_stall();
    test_lone_strobe();
    test_async_reset();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass,
             n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
